// File: rtl/seg7_scan_mux.sv
// N-digit common-anode 7-seg scanner: frame-coherent capture, per-digit blank/dp, 16-level PWM, frame_start strobe.
// Latency: outputs registered one cycle behind slot/idx state; first cycle after reset is a blank capture cycle.
// Backpressure: none, free-running. Optional SEG_BLINK_EN adds blink_mask and a frame counter for 50% blinking.
module seg7_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_LOG2   = 16,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [3:0]              brightness,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);

    logic [DIV_LOG2-1:0]     slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    start_q, start_d;
    logic [4*NUM_DIGITS-1:0] dig_sh_q, dig_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_start_q, frame_start_d;
`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic [BLINK_LOG2:0]     frame_cnt_q, frame_cnt_d;
`endif

    logic       slot_wrap, last_idx, cap, lit, on;
    logic [3:0] cur_nib;
    logic [3:0] duty;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        slot_wrap     = &slot_cnt_q;
        last_idx      = (idx_q == IW'(NUM_DIGITS - 1));
        // The post-reset cycle captures inputs and holds the counters so frame 0 starts like any other frame.
        cap           = start_q | (slot_wrap & last_idx);
        start_d       = 1'b0;
        slot_cnt_d    = start_q ? slot_cnt_q : slot_cnt_q + 1'b1;
        idx_d         = idx_q;
        if (!start_q && slot_wrap)
            idx_d = last_idx ? '0 : idx_q + 1'b1;

        dig_sh_d      = cap ? digits : dig_sh_q;
        dp_sh_d       = cap ? dp_in  : dp_sh_q;
        blank_sh_d    = cap ? blank  : blank_sh_q;
        frame_start_d = cap;

        cur_nib = dig_sh_q[{idx_q, 2'b00} +: 4];
        duty    = slot_cnt_q[DIV_LOG2-1 -: 4];
        lit     = (duty <= brightness);
        on      = en & lit & ~blank_sh_q[idx_q] & ~start_q;
`ifdef SEG_BLINK_EN
        blink_sh_d  = cap ? blink_mask : blink_sh_q;
        frame_cnt_d = frame_cnt_q + {{BLINK_LOG2{1'b0}}, (cap & ~start_q)};
        on          = on & ~(blink_sh_q[idx_q] & frame_cnt_q[BLINK_LOG2]);
`endif

        anode_d = '1;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (on) begin
            anode_d[idx_q] = 1'b0;
            seg_d          = decode(cur_nib);
            dp_d           = ~dp_sh_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            idx_q         <= '0;
            start_q       <= 1'b1;
            dig_sh_q      <= '0;
            dp_sh_q       <= '0;
            blank_sh_q    <= '0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            anode_q       <= '1;
            frame_start_q <= 1'b0;
`ifdef SEG_BLINK_EN
            blink_sh_q    <= '0;
            frame_cnt_q   <= '0;
`endif
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            start_q       <= start_d;
            dig_sh_q      <= dig_sh_d;
            dp_sh_q       <= dp_sh_d;
            blank_sh_q    <= blank_sh_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            anode_q       <= anode_d;
            frame_start_q <= frame_start_d;
`ifdef SEG_BLINK_EN
            blink_sh_q    <= blink_sh_d;
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign anode       = anode_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux against a frame-level reference model.
module tb_seg7_scan_mux;

    localparam int N = 4;
    localparam int D = 4;
    localparam int S = 1 << D;
    localparam int F = S * N;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   blank;
    logic [3:0]     brightness;
    logic [N-1:0]   blink_mask;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   anode;
    logic           frame_start;

    int checks = 0;
    int errors = 0;

    seg7_scan_mux #(.NUM_DIGITS(N), .DIV_LOG2(D), .BLINK_LOG2(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
        .blank(blank), .brightness(brightness),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg), .dp(dp), .anode(anode), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference: p counts scan cycles since the capture cycle; shadow values change only at frame boundaries.
    bit             m_first;
    int             m_p, m_fr;
    logic [4*N-1:0] m_dig;
    logic [N-1:0]   m_dp, m_blank, m_blink;
    logic [6:0]     e_seg;
    logic           e_dp, e_fs;
    logic [N-1:0]   e_an;

    task automatic model_capture();
        m_dig   = digits;
        m_dp    = dp_in;
        m_blank = blank;
        m_blink = blink_mask;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_first = 1'b1; m_p = 0; m_fr = 0;
            m_dig = '0; m_dp = '0; m_blank = '0; m_blink = '0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fs = 1'b0;
        end else if (m_first) begin
            m_first = 1'b0;
            model_capture();
            e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fs = 1'b1;
        end else begin
            int  slot, idx;
            bit  on;
            slot = m_p % S;
            idx  = (m_p / S) % N;
            on   = en && ((slot / (S / 16)) <= int'(brightness)) && !m_blank[idx];
`ifdef SEG_BLINK_EN
            if (m_blink[idx] && ((m_fr / 2) % 2 == 1)) on = 1'b0;
`endif
            e_an  = on ? ~(N'(1) << idx) : '1;
            e_seg = on ? tbl[m_dig[idx*4 +: 4]] : 7'h7F;
            e_dp  = on ? ~m_dp[idx] : 1'b1;
            e_fs  = (m_p % F == F - 1);
            if (e_fs) begin
                model_capture();
                m_fr++;
            end
            m_p++;
        end
    end

    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dp", 32'(dp), 32'(e_dp));
            chk("anode", 32'(anode), 32'(e_an));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
            chk("one_anode", 32'($countones(~anode) <= 1), 32'd1);
        end
    end

    task automatic randomize_inputs();
        digits     = {$urandom, $urandom};
        dp_in      = N'($urandom);
        blank      = N'($urandom & $urandom);
        brightness = 4'($urandom);
        en         = ($urandom_range(0, 7) != 0);
        blink_mask = N'($urandom);
    endtask

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: digits = {$urandom, $urandom};
                    1: brightness = 4'($urandom);
                    2: begin dp_in = N'($urandom); blank = N'($urandom & $urandom); end
                    default: en = ($urandom_range(0, 7) != 0);
                endcase
            end
        end
    endtask

    logic [N-1:0] exp_an  [N] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]   exp_seg [N] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};

    initial begin
        bit seen;
        rst_n = 1'b0;
        randomize_inputs();
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_fs", 32'(frame_start), 32'd0);

        digits = 16'h1A3F; brightness = 4'd15; en = 1'b1;
        blank = '0; dp_in = 4'b0001; blink_mask = '0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = frame_start;
        end
        chk("fs_after_reset", 32'(seen), 32'd1);
        for (int k = 0; k < N; k++) begin
            repeat (8) @(negedge clk);
            chk("scan_anode", 32'(anode), 32'(exp_an[k]));
            chk("scan_seg", 32'(seg), 32'(exp_seg[k]));
            chk("scan_dp", 32'(dp), (k == 0) ? 32'd0 : 32'd1);
            repeat (8) @(negedge clk);
        end

        // Mid-frame change must not appear until the next frame.
        digits = 16'h0000;
        repeat (2 * F) @(negedge clk);
        repeat (S + 5) @(negedge clk);
        digits = 16'h8888;
        chk("coherent_old", 32'(seg), 32'h40);
        seen = 1'b0;
        for (int i = 0; i < 2 * F && !seen; i++) begin
            @(negedge clk);
            seen = frame_start;
        end
        chk("fs_period_wait", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        chk("coherent_new", 32'(seg), 32'h00);

        randomize_inputs();
        run_random(40 * F);

        // Asynchronous reset mid-frame.
        repeat (S * 2 + 3) @(negedge clk);
        en = 1'b1; brightness = 4'd15; blank = '0;
        repeat (F) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'd1);
        chk("arst_anode", 32'(anode), 32'hF);
        chk("arst_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_random(20 * F);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
